// File: rtl/apb_rr_pkg.sv
// apb_rr_pkg: shared types and bus widths for the round-robin APB master.
package apb_rr_pkg;

  localparam int APB_DW = 32;
  localparam int APB_AW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
    logic [3:0]        strb;
  } apb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant over N requesters.
// The grant is combinational; the pointer holds the index where the next
// search starts and moves to (winner+1) mod N only when advance is high.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         pclk,
  input  logic         preset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW:0] NW = (IW+1)'(N);

  logic [IW-1:0] ptr_q, ptr_d;

  // Search from the pointer upward with wrap; first requester found wins.
  always_comb begin
    logic          found;
    logic [IW:0]   idx;
    logic [IW:0]   nxt;
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    nxt   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (idx >= NW) idx = idx - NW;
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        gnt[idx[IW-1:0]] = 1'b1;
        nxt = idx + (IW+1)'(1);
        if (nxt >= NW) nxt = '0;
        ptr_d = nxt[IW-1:0];
      end
    end
    if (!advance) ptr_d = ptr_q;
  end

  // Pointer register; restarts the search at requester 0 after reset.
  always_ff @(posedge pclk) begin
    if (preset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master: APB master shared by NREQ requesters with round-robin
// arbitration. Build macro APB_TIMEOUT_EN adds an ACCESS-phase timeout that
// aborts the transfer with rsp_err; without it ACCESS waits for pready forever.
//
// state  | meaning
// IDLE   | bus quiet; any pending request is granted and latched
// SETUP  | psel driven for the decoded slave, penable low
// ACCESS | penable high; completes on pready (or aborts on timeout)
module apb_rr_master #(
  parameter int NREQ    = 4,
  parameter int NSLV    = 4,
  parameter int SLV_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_wdata,
  input  logic [NREQ*4-1:0] req_strb,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       paddr,
  output logic [NSLV-1:0]   psel,
  output logic              penable,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  output logic [3:0]        pstrb,
  input  logic [31:0]       prdata,
  input  logic              pready
);

  import apb_rr_pkg::*;

  localparam int IW = $clog2(NREQ);
  localparam int SW = $clog2(NSLV);

  if (NREQ < 2 || NREQ > 8 || NSLV < 2 || (NSLV & (NSLV - 1)) != 0 || TIMEOUT < 1)
  begin : g_bad_param
    $error("apb_rr_master: unsupported parameter set");
  end

  apb_state_t      state_q, state_d;
  apb_req_t        req_q, req_d, req_sel;
  logic [IW-1:0]   gidx_q, gidx_d, win_idx;
  logic [NSLV-1:0] psel_q, psel_d, psel_dec;
  logic            penable_q, penable_d;
  logic [NREQ-1:0] gnt;
  logic            take, done, abort, go_idle;

  rr_arbiter #(.N(NREQ)) u_arb (
    .pclk    (pclk),
    .preset  (preset),
    .req     (req_valid),
    .advance (take),
    .gnt     (gnt)
  );

  // Winner index and its payload; read strobes are zeroed at capture.
  always_comb begin
    win_idx = '0;
    for (int k = 0; k < NREQ; k++)
      if (gnt[k]) win_idx = IW'(k);
    req_sel.write = req_write[win_idx];
    req_sel.addr  = req_addr[APB_AW*win_idx +: APB_AW];
    req_sel.wdata = req_wdata[APB_DW*win_idx +: APB_DW];
    req_sel.strb  = req_write[win_idx] ? req_strb[4*win_idx +: 4] : 4'h0;
    psel_dec = '0;
    psel_dec[req_sel.addr[SLV_LSB +: SW]] = 1'b1;
  end

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q, tmr_d;
`endif

  // Next-state logic; a reset cycle suppresses every handshake pulse.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    gidx_d    = gidx_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    take      = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    go_idle   = 1'b0;
    if (!preset) begin
      case (state_q)
        IDLE:   take = |req_valid;
        SETUP: begin
          state_d   = ACCESS;
          penable_d = 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            done    = 1'b1;
            take    = |req_valid;
            go_idle = ~take;
          end
`ifdef APB_TIMEOUT_EN
          else if (tmr_q == '0) begin
            abort   = 1'b1;
            go_idle = 1'b1;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
    if (go_idle) begin
      state_d   = IDLE;
      psel_d    = '0;
      penable_d = 1'b0;
    end
    if (take) begin
      state_d   = SETUP;
      req_d     = req_sel;
      gidx_d    = win_idx;
      psel_d    = psel_dec;
      penable_d = 1'b0;
    end
  end

`ifdef APB_TIMEOUT_EN
  // ACCESS timer: loaded on every grant, counts down while pready is low.
  always_comb begin
    tmr_d = tmr_q;
    if (take)
      tmr_d = TW'(TIMEOUT - 1);
    else if (state_q == ACCESS && !pready && tmr_q != '0)
      tmr_d = tmr_q - TW'(1);
  end

  // Timer register.
  always_ff @(posedge pclk) begin
    if (preset) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end
`endif

  // FSM and APB-side registers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      gidx_q    <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      gidx_q    <= gidx_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  // Requester-side handshake pulses and APB outputs.
  always_comb begin
    req_ready = take ? gnt : '0;
    for (int k = 0; k < NREQ; k++)
      rsp_valid[k] = (done || abort) && (gidx_q == IW'(k));
    rsp_rdata = (done && !req_q.write) ? prdata : 32'h0;
    rsp_err   = abort;
    paddr     = req_q.addr;
    pwrite    = req_q.write;
    pwdata    = req_q.wdata;
    pstrb     = req_q.strb;
    psel      = psel_q;
    penable   = penable_q;
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: directed bench for apb_rr_master (default parameters).
// Inputs change 2 ns after each rising edge; outputs are checked 1 ns later.
module tb_apb_rr_master;

  logic         pclk = 1'b0;
  logic         preset;
  logic [3:0]   req_valid, req_write;
  logic [127:0] req_addr, req_wdata;
  logic [15:0]  req_strb;
  logic [3:0]   req_ready, rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [31:0]  paddr;
  logic [3:0]   psel;
  logic         penable, pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  prdata;
  logic         pready;

  int checks = 0;
  int errors = 0;

  apb_rr_master dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #2;
  endtask

  task automatic test_reset();
    preset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0;
    req_wdata = '0; req_strb = '0; prdata = '0; pready = 1'b1;
    tick(); tick(); tick();
    preset = 1'b0;
    #1;
    checks++; if (psel !== 4'h0) begin errors++; $display("FAIL rst_psel got %h exp 0", psel); end
    checks++; if (penable !== 1'b0) begin errors++; $display("FAIL rst_penable got %b exp 0", penable); end
    checks++; if (pstrb !== 4'h0) begin errors++; $display("FAIL rst_pstrb got %h exp 0", pstrb); end
    checks++; if (paddr !== 32'h0) begin errors++; $display("FAIL rst_paddr got %h exp 0", paddr); end
    checks++; if (rsp_valid !== 4'h0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_rsp got v=%h e=%b d=%h exp all 0", rsp_valid, rsp_err, rsp_rdata); end
  endtask

  task automatic test_single_write();
    tick();
    req_valid = 4'b0001; req_write = 4'b0001;
    req_addr[31:0] = 32'h0000_1004; req_wdata[31:0] = 32'hA5A5_0001; req_strb[3:0] = 4'b0011;
    pready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wr_ready got %b exp 0001", req_ready); end
    tick(); req_valid = '0; #1;
    checks++; if (psel !== 4'b0010 || penable !== 1'b0) begin
      errors++; $display("FAIL wr_setup got psel=%b pen=%b exp 0010/0", psel, penable); end
    checks++; if (paddr !== 32'h0000_1004 || pwrite !== 1'b1 || rsp_valid !== 4'h0) begin
      errors++; $display("FAIL wr_setup_bus got a=%h w=%b rv=%h", paddr, pwrite, rsp_valid); end
    tick(); #1;
    checks++; if (penable !== 1'b1 || pstrb !== 4'h3 || pwdata !== 32'hA5A5_0001) begin
      errors++; $display("FAIL wr_access got pen=%b strb=%h wd=%h exp 1/3/a5a50001", penable, pstrb, pwdata); end
    checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL wr_rsp got v=%b e=%b d=%h exp 0001/0/0", rsp_valid, rsp_err, rsp_rdata); end
    tick(); #1;
    checks++; if (psel !== 4'h0 || penable !== 1'b0 || rsp_valid !== 4'h0) begin
      errors++; $display("FAIL wr_idle got psel=%b pen=%b rv=%b exp 0", psel, penable, rsp_valid); end
  endtask

  task automatic test_read_wait();
    req_valid = 4'b0100; req_write = 4'b0000;
    req_addr[95:64] = 32'h0000_3000; req_strb[11:8] = 4'hF;
    pready = 1'b0; prdata = 32'h1234_5678;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rd_ready got %b exp 0100", req_ready); end
    tick(); req_valid = '0; #1;
    checks++; if (psel !== 4'b1000 || pwrite !== 1'b0) begin
      errors++; $display("FAIL rd_setup got psel=%b w=%b exp 1000/0", psel, pwrite); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) begin pready = 1'b1; prdata = 32'hDEAD_BEEF; end
      #1;
      checks++; if (penable !== 1'b1 || pstrb !== 4'h0 || psel !== 4'b1000) begin
        errors++; $display("FAIL rd_access%0d got pen=%b strb=%h psel=%b", c, penable, pstrb, psel); end
      checks++; if (rsp_valid !== ((c == 4) ? 4'b0100 : 4'b0000)) begin
        errors++; $display("FAIL rd_rsp_valid%0d got %b", c, rsp_valid); end
    end
    checks++; if (rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_rdata got %h exp deadbeef", rsp_rdata); end
    tick(); #1;
    checks++; if (psel !== 4'h0 || penable !== 1'b0) begin
      errors++; $display("FAIL rd_idle got psel=%b pen=%b", psel, penable); end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    req_valid = 4'b0010; req_write = 4'b0010; req_addr[63:32] = 32'h0000_2000;
    req_wdata[63:32] = 32'h5555_AAAA; req_strb[7:4] = 4'hF; pready = 1'b0;
    tick(); req_valid = '0;
    tick(); #1;
    checks++; if (penable !== 1'b1 || psel !== 4'b0100) begin
      errors++; $display("FAIL rm_access got pen=%b psel=%b exp 1/0100", penable, psel); end
    preset = 1'b1; pready = 1'b1; #1;
    checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL rm_rsp_in_reset got %b exp 0", rsp_valid); end
    tick(); #1;
    checks++; if (psel !== 4'h0 || penable !== 1'b0) begin
      errors++; $display("FAIL rm_drop got psel=%b pen=%b exp 0/0", psel, penable); end
    tick(); tick(); preset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1; if (rsp_valid !== 4'h0 || psel !== 4'h0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rm_no_rsp got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_contention();
    int exp_g [6] = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 4; i++) begin
      req_addr[32*i +: 32]  = 32'h0000_0000 | (i << 12) | (i << 2);
      req_wdata[32*i +: 32] = 32'h1111_0000 | i;
      req_strb[4*i +: 4]    = 4'(i + 1);
    end
    req_write = 4'hF; req_valid = 4'hF; pready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ct_first_ready got %b exp 0001", req_ready); end
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      checks++; if (penable !== 1'b0 || psel !== 4'(1 << exp_g[k]) || paddr !== ((exp_g[k] << 12) | (exp_g[k] << 2))) begin
        errors++; $display("FAIL ct_setup%0d got pen=%b psel=%b a=%h grant exp %0d", k, penable, psel, paddr, exp_g[k]); end
      tick(); #1;
      checks++; if (rsp_valid !== 4'(1 << exp_g[k]) || pstrb !== 4'(exp_g[k] + 1)) begin
        errors++; $display("FAIL ct_rsp%0d got rv=%b strb=%h exp grant %0d", k, rsp_valid, pstrb, exp_g[k]); end
      checks++; if (req_ready !== 4'(1 << exp_g[k+1])) begin
        errors++; $display("FAIL ct_next_ready%0d got %b exp grant %0d", k, req_ready, exp_g[k+1]); end
    end
    tick(); req_valid = '0;
    tick(); tick(); #1;
    checks++; if (psel !== 4'h0 || penable !== 1'b0) begin
      errors++; $display("FAIL ct_idle got psel=%b pen=%b", psel, penable); end
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    req_valid = 4'b0001; req_write = 4'b0001; req_addr[31:0] = 32'h0000_0040;
    req_strb[3:0] = 4'h0; pready = 1'b0; prdata = 32'hFFFF_FFFF;
    tick(); req_valid = '0;
`ifdef APB_TIMEOUT_EN
    for (int c = 1; c <= 16; c++) begin
      tick(); #1;
      if (c < 16 && (penable !== 1'b1 || rsp_valid !== 4'h0)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL to_wait got %0d bad cycles exp 0", bad); end
    checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL to_abort got v=%b e=%b d=%h exp 0001/1/0", rsp_valid, rsp_err, rsp_rdata); end
    tick(); #1;
    checks++; if (psel !== 4'h0 || penable !== 1'b0 || rsp_valid !== 4'h0) begin
      errors++; $display("FAIL to_idle got psel=%b pen=%b rv=%b", psel, penable, rsp_valid); end
    pready = 1'b1;
`else
    for (int c = 1; c <= 100; c++) begin
      tick(); #1;
      if (penable !== 1'b1 || psel !== 4'b0001 || rsp_valid !== 4'h0 || rsp_err !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL to_persist got %0d bad cycles exp 0", bad); end
    checks++; if (pstrb !== 4'h0 || pwrite !== 1'b1) begin
      errors++; $display("FAIL to_zero_strb got strb=%h w=%b exp 0/1", pstrb, pwrite); end
    tick(); pready = 1'b1; #1;
    checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL to_late_rsp got v=%b e=%b d=%h exp 0001/0/0", rsp_valid, rsp_err, rsp_rdata); end
    tick(); #1;
    checks++; if (psel !== 4'h0 || penable !== 1'b0) begin
      errors++; $display("FAIL to_idle got psel=%b pen=%b", psel, penable); end
`endif
  endtask

  task automatic test_back_to_back();
    req_valid = 4'b0010; req_write = 4'b0000; req_addr[63:32] = 32'h0000_2008;
    pready = 1'b1; prdata = 32'h0BAD_F00D;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bb_ready got %b exp 0010", req_ready); end
    tick(); tick(); #1;
    checks++; if (rsp_valid !== 4'b0010 || req_ready !== 4'b0010 || rsp_rdata !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL bb_regrant got rv=%b rr=%b d=%h", rsp_valid, req_ready, rsp_rdata); end
    tick(); req_valid = '0; #1;
    checks++; if (psel !== 4'b0100 || penable !== 1'b0) begin
      errors++; $display("FAIL bb_setup got psel=%b pen=%b exp 0100/0", psel, penable); end
    tick(); #1;
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL bb_rsp2 got %b exp 0010", rsp_valid); end
    tick(); #1;
    checks++; if (psel !== 4'h0) begin errors++; $display("FAIL bb_idle got psel=%b exp 0", psel); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_reset_mid();
    test_contention();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
